// File: rtl/game_vga_timing_if.sv
// game_vga_timing_if: raster position and sync bundle from the VGA timing
// generator to the game logic and the board video pins.
//   hsync, vsync   active-low sync pulses
//   display_on     current position is inside the visible area
//   x, y           visible column/row (0 outside the visible area)
//   pixel_en       one-clk pulse at the start of every pixel position
//   frame_start    one-clk pulse at the start of position (0,0)
// master = timing generator, slave = consumer.
interface game_vga_timing_if #(
    parameter int unsigned w_x = 10,
    parameter int unsigned w_y = 9
);
    logic           hsync;
    logic           vsync;
    logic           display_on;
    logic [w_x-1:0] x;
    logic [w_y-1:0] y;
    logic           pixel_en;
    logic           frame_start;

    modport master (
        output hsync, vsync, display_on, x, y, pixel_en, frame_start
    );

    modport slave (
        input hsync, vsync, display_on, x, y, pixel_en, frame_start
    );
endinterface

// File: rtl/game_vga_timing.sv
// game_vga_timing: divides clk down to the pixel rate, scans an
// H_TOTAL x V_TOTAL raster and drives registered position/sync decode.
//   clk   in   system clock, all state on rising edge
//   rst   in   asynchronous active-high reset
//   vga   master modport of game_vga_timing_if (hsync, vsync, display_on,
//         x, y, pixel_en, frame_start), all registered
module game_vga_timing #(
    parameter int unsigned clk_mhz       = 50,
    parameter int unsigned pixel_mhz     = 25,
    parameter int unsigned screen_width  = 640,
    parameter int unsigned screen_height = 480,
    parameter int unsigned h_front       = 16,
    parameter int unsigned h_sync        = 96,
    parameter int unsigned h_back        = 48,
    parameter int unsigned v_front       = 10,
    parameter int unsigned v_sync        = 2,
    parameter int unsigned v_back        = 33,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height)
) (
    input  logic               clk,
    input  logic               rst,
    game_vga_timing_if.master  vga
);

    localparam int unsigned RATIO    = clk_mhz / pixel_mhz;
    localparam int unsigned H_TOTAL  = screen_width + h_front + h_sync + h_back;
    localparam int unsigned V_TOTAL  = screen_height + v_front + v_sync + v_back;
    localparam int unsigned W_H      = $clog2(H_TOTAL);
    localparam int unsigned W_V      = $clog2(V_TOTAL);
    localparam int unsigned HS_START = screen_width + h_front;
    localparam int unsigned HS_END   = HS_START + h_sync;
    localparam int unsigned VS_START = screen_height + v_front;
    localparam int unsigned VS_END   = VS_START + v_sync;

    logic           tick;
    logic [W_H-1:0] h_cnt;
    logic [W_H-1:0] h_nxt;
    logic [W_V-1:0] v_cnt;
    logic [W_V-1:0] v_nxt;
    logic           h_wrap;
    logic           display_nxt;
    logic           hsync_nxt;
    logic           vsync_nxt;
    logic [w_x-1:0] x_nxt;
    logic [w_y-1:0] y_nxt;

    // Pixel-rate tick: last clk of each divider period, or every clk at R = 1.
    generate
        if (RATIO > 1) begin : g_div
            localparam int unsigned W_D = $clog2(RATIO);
            logic [W_D-1:0] div;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    div <= '0;
                end else if (div == W_D'(RATIO - 1)) begin
                    div <= '0;
                end else begin
                    div <= div + W_D'(1);
                end
            end

            assign tick = (div == W_D'(RATIO - 1));
        end else begin : g_no_div
            assign tick = 1'b1;
        end
    endgenerate

    // Next raster position and its decode; comparisons done at 32 bits so a
    // sync window ending exactly at the total cannot overflow the counter width.
    always_comb begin
        h_wrap = (h_cnt == W_H'(H_TOTAL - 1));
        h_nxt  = h_wrap ? '0 : h_cnt + W_H'(1);
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == W_V'(V_TOTAL - 1)) ? '0 : v_cnt + W_V'(1);
        end
        display_nxt = (32'(h_nxt) < screen_width) && (32'(v_nxt) < screen_height);
        hsync_nxt   = !((32'(h_nxt) >= HS_START) && (32'(h_nxt) < HS_END));
        vsync_nxt   = !((32'(v_nxt) >= VS_START) && (32'(v_nxt) < VS_END));
        x_nxt       = display_nxt ? w_x'(h_nxt) : '0;
        y_nxt       = display_nxt ? w_y'(v_nxt) : '0;
    end

    // Counters and outputs; reset parks on the last position so the first
    // tick lands on (0,0) and the reset outputs match that parked decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt           <= W_H'(H_TOTAL - 1);
            v_cnt           <= W_V'(V_TOTAL - 1);
            vga.hsync       <= 1'b1;
            vga.vsync       <= 1'b1;
            vga.display_on  <= 1'b0;
            vga.x           <= '0;
            vga.y           <= '0;
            vga.pixel_en    <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.pixel_en    <= tick;
            vga.frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
            if (tick) begin
                h_cnt          <= h_nxt;
                v_cnt          <= v_nxt;
                vga.hsync      <= hsync_nxt;
                vga.vsync      <= vsync_nxt;
                vga.display_on <= display_nxt;
                vga.x          <= x_nxt;
                vga.y          <= y_nxt;
            end
        end
    end

endmodule
